// File: rtl/icache_dm_param_if.sv
// Fetch-side and Wishbone-fill signal bundle for icache_dm_param.
// slave is the cache; master is the fetch unit plus memory environment.
interface icache_dm_param_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] adr_i;
  logic              stb_i;
  logic              inv_i;
  logic              hit_o;
  logic [15:0]       inst_o;
  logic [31:0]       data_o;
  logic              busy_o;
  logic              err_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [15:0]       wb_dat_i;
  logic [1:0]        wb_sel_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport slave (
    input  adr_i, stb_i, inv_i, wb_dat_i, wb_ack_i, wb_err_i,
    output hit_o, inst_o, data_o, busy_o, err_o,
    output wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );

  modport master (
    output adr_i, stb_i, inv_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  hit_o, inst_o, data_o, busy_o, err_o,
    input  wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/icache_dm_param.sv
// Direct-mapped I-cache returning a 48-bit fetch window; hits in 0 cycles, misses fill one or two
// lines over 16-bit Wishbone classic, one halfword per ack, stalling (hit_o low) until the window is resident.
module icache_dm_param #(
  parameter int LINE_BYTES = 32,
  parameter int NUM_LINES  = 256,
  parameter int ADDR_W     = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  icache_dm_param_if.slave bus
);
  localparam int HW_PER_LINE = LINE_BYTES / 2;
  localparam int OFF_W       = $clog2(HW_PER_LINE);
  localparam int IDX_W       = $clog2(NUM_LINES);
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W - 1;
  localparam int LINE_W      = ADDR_W - OFF_W - 1;
  localparam int HW_W        = ADDR_W - 1;
  localparam int DIDX_W      = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(HW_PER_LINE - 1);
  localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, GAP} state_t;
  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [15:0]          data_q [NUM_LINES*HW_PER_LINE];

  // Halfword addresses of the three window slots; adds wrap at the top of the address space.
  logic [HW_W-1:0]   h0, h1, h2;
  logic [LINE_W-1:0] line0, line1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [TAG_W-1:0]  tag0, tag1;
  logic              hit0, hit1, lookup_hit;

  assign h0    = bus.adr_i[ADDR_W-1:1];
  assign h1    = h0 + HW_W'(1);
  assign h2    = h0 + HW_W'(2);
  assign line0 = h0[HW_W-1:OFF_W];
  assign line1 = h2[HW_W-1:OFF_W];
  assign idx0  = line0[IDX_W-1:0];
  assign idx1  = line1[IDX_W-1:0];
  assign tag0  = line0[LINE_W-1:IDX_W];
  assign tag1  = line1[LINE_W-1:IDX_W];

  assign hit0       = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1       = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign lookup_hit = hit0 && hit1;

  assign bus.inst_o = data_q[h0[DIDX_W-1:0]];
  assign bus.data_o = {data_q[h1[DIDX_W-1:0]], data_q[h2[DIDX_W-1:0]]};
  assign bus.hit_o  = !rst_i && (state_q == IDLE) && lookup_hit;

  logic unused_bits;
  assign unused_bits = ^{bus.adr_i[0], h1[HW_W-1:DIDX_W]};

  // Fill bookkeeping
  logic [LINE_W-1:0] fill_line_q, next_line_q;
  logic [OFF_W-1:0]  cnt_q;
  logic              pend2_q, inv_pend_q, err_q;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              fill_act, inv_seen;
  logic              start, beat_wr, line_done, abort;

  assign fill_idx = fill_line_q[IDX_W-1:0];
  assign fill_tag = fill_line_q[LINE_W-1:IDX_W];
  assign fill_act = !rst_i && (state_q == FILL);
  assign inv_seen = inv_pend_q || bus.inv_i;

  assign bus.wb_stb_o = fill_act;
  assign bus.wb_cyc_o = fill_act;
  assign bus.wb_sel_o = {2{fill_act}};
  assign bus.wb_adr_o = fill_act ? {fill_line_q, cnt_q, 1'b0} : '0;
  assign bus.busy_o   = !rst_i && (state_q != IDLE);
  assign bus.err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    beat_wr   = 1'b0;
    line_done = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.stb_i && !lookup_hit) begin
          state_d = FILL;
          start   = 1'b1;
        end
      end
      FILL: begin
        if (bus.wb_err_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (bus.wb_ack_i) begin
          beat_wr = 1'b1;
          if (cnt_q == CNT_LAST) begin
            line_done = 1'b1;
            state_d   = (pend2_q && !inv_seen) ? GAP : IDLE;
          end
        end
      end
      GAP:     state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      cnt_q       <= '0;
      pend2_q     <= 1'b0;
      inv_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      fill_line_q <= '0;
      next_line_q <= '0;
    end else begin
      err_q <= abort;
      if (start) begin
        // L0 first when it is missing; the second line is only queued when both miss.
        fill_line_q <= hit0 ? line1 : line0;
        next_line_q <= line1;
        pend2_q     <= !hit0 && !hit1 && (line1 != line0);
        cnt_q       <= '0;
      end
      if (state_q == IDLE) begin
        inv_pend_q <= 1'b0;
        if (bus.inv_i) valid_q <= '0;
      end else if (bus.inv_i) begin
        inv_pend_q <= 1'b1;
      end
      if (abort) begin
        cnt_q   <= '0;
        pend2_q <= 1'b0;
        if (inv_seen) valid_q <= '0;
      end
      if (beat_wr) cnt_q <= cnt_q + CNT_ONE;
      if (line_done) begin
        fill_line_q <= next_line_q;
        pend2_q     <= 1'b0;
        if (inv_seen) valid_q <= '0;
        else          valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_wr && !rst_i)   data_q[{fill_idx, cnt_q}] <= bus.wb_dat_i;
    if (line_done && !rst_i) tag_q[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_dm_param.sv
// Scoreboarded bench for icache_dm_param: directed scenarios then randomized fetches
// against a memory whose halfword at byte address a is a[16:1] ^ a[31:16].
module tb_icache_dm_param;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_dm_param_if #(.ADDR_W(ADDR_W)) bus ();

  icache_dm_param #(.LINE_BYTES(32), .NUM_LINES(256), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] inst;
    logic [31:0] data;
  } win_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          hits_seen = 0;
  int          n_timeouts = 0;
  win_t        exp_q[$];
  logic [31:0] ack_log[$];
  int          ack_pct = 100;
  int          err_pct = 0;
  int          err_beat = 0;
  logic        inv_dir = 1'b0;
  logic        inv_rnd = 1'b0;
  bit          inv_rand_en = 1'b0;

  assign bus.inv_i = inv_dir | inv_rnd;

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    return a[16:1] ^ a[31:16];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted window is popped against the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.stb_i && bus.hit_o) begin
      if (exp_q.size() == 0) chk("unexpected_hit", 64'(exp_q.size()), 64'd1);
      else begin
        win_t w;
        w = exp_q.pop_front();
        chk("window", {bus.inst_o, bus.data_o}, {w.inst, w.data});
      end
      hits_seen++;
    end
  end

  // Wishbone memory: acks/errors driven at the falling edge for the next rising edge.
  initial begin
    int beat;
    beat = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (!rst) chk("wb_cyc_eq_stb", 64'(bus.wb_cyc_o), 64'(bus.wb_stb_o));
      if (bus.wb_cyc_o) begin
        chk("wb_sel", 64'(bus.wb_sel_o), 64'd3);
        if (err_beat != 0 && beat + 1 == err_beat) begin
          bus.wb_err_i = 1'b1;
        end else if (err_pct != 0 && $urandom_range(99) < err_pct) begin
          bus.wb_err_i = 1'b1;
        end else if ($urandom_range(99) < ack_pct) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = mem_hw(bus.wb_adr_o);
          ack_log.push_back(bus.wb_adr_o);
          beat++;
        end
      end else begin
        beat = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      inv_rnd = inv_rand_en && ($urandom_range(63) == 0);
    end
  end

  task automatic fetch(input logic [31:0] a, output int lat);
    win_t        w;
    int          h0;
    bit          got;
    logic [31:0] b;
    b = {a[31:1], 1'b0};
    w.inst = mem_hw(b);
    w.data = {mem_hw(b + 32'd2), mem_hw(b + 32'd4)};
    exp_q.push_back(w);
    h0 = hits_seen;
    got = 1'b0;
    lat = 0;
    bus.adr_i = a;
    bus.stb_i = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk);
      if (hits_seen != h0) begin
        lat = c;
        got = 1'b1;
        break;
      end
    end
    #1;
    bus.stb_i = 1'b0;
    chk("fetch_completes", 64'(got), 64'd1);
    if (!got) begin
      void'(exp_q.pop_back());
      n_timeouts++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat, base, got;
    int          idx_tab[6];
    logic [31:0] a, hi;
    idx_tab = '{0, 1, 2, 8, 254, 255};
    bus.adr_i = 32'h100;
    bus.stb_i = 1'b1;

    // Reset state, with a request held during reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hit", 64'(bus.hit_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("rst_sel", 64'(bus.wb_sel_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    @(posedge clk);
    #1;
    bus.stb_i = 1'b0;
    rst = 1'b0;
    step();

    // T1 cold miss
    base = ack_log.size();
    fetch(32'h100, lat);
    chk("t1_latency", 64'(lat), 64'd18);
    chk("t1_beats", 64'(ack_log.size() - base), 64'd16);
    for (int i = 0; i < 16 && base + i < ack_log.size(); i++)
      chk("t1_beat_adr", 64'(ack_log[base+i]), 64'(32'h100 + 2 * i));

    // T2 line crossing
    base = ack_log.size();
    fetch(32'h13C, lat);
    chk("t2_beats", 64'(ack_log.size() - base), 64'd32);
    if (ack_log.size() - base == 32) begin
      chk("t2_first_line", 64'(ack_log[base]), 64'h120);
      chk("t2_second_line", 64'(ack_log[base+16]), 64'h140);
    end

    // T3 index wrap with a stale tag-0 line in set 0
    fetch(32'h0, lat);
    base = ack_log.size();
    fetch(32'h1FFE, lat);
    chk("t3_beats", 64'(ack_log.size() - base), 64'd32);
    if (ack_log.size() - base == 32) begin
      chk("t3_first_line", 64'(ack_log[base]), 64'h1FE0);
      chk("t3_second_line", 64'(ack_log[base+16]), 64'h2000);
    end
    base = ack_log.size();
    fetch(32'h1FFC, lat);
    chk("t3_rehit_latency", 64'(lat), 64'd1);
    chk("t3_rehit_beats", 64'(ack_log.size() - base), 64'd0);

    // Window wrapping past the top of the address space
    base = ack_log.size();
    fetch(32'hFFFF_FFFC, lat);
    chk("top_wrap_beats", 64'(ack_log.size() - base), 64'd32);
    if (ack_log.size() - base == 32) chk("top_wrap_second", 64'(ack_log[base+16]), 64'h0);

    // T4 bus error on the fifth beat
    base = ack_log.size();
    err_beat = 5;
    bus.adr_i = 32'h400;
    bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.err_o) begin
        got = 1;
        break;
      end
    end
    chk("t4_err_seen", 64'(got), 64'd1);
    if (got != 0) begin
      chk("t4_busy", 64'(bus.busy_o), 64'd0);
      chk("t4_hit", 64'(bus.hit_o), 64'd0);
      chk("t4_stb", 64'(bus.wb_stb_o), 64'd0);
      chk("t4_beats_before_err", 64'(ack_log.size() - base), 64'd4);
      @(negedge clk);
      chk("t4_err_one_cycle", 64'(bus.err_o), 64'd0);
    end
    step();
    err_beat = 0;
    base = ack_log.size();
    fetch(32'h400, lat);
    chk("t4_refetch_beats", 64'(ack_log.size() - base), 64'd16);
    if (ack_log.size() > base) chk("t4_refetch_adr", 64'(ack_log[base]), 64'h400);

    // T5 invalidate during a fill
    fetch(32'h100, lat);
    chk("t5_resident", 64'(lat), 64'd1);
    base = ack_log.size();
    bus.adr_i = 32'h200;
    bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0;
    for (int c = 0; c < 100 && ack_log.size() - base < 5; c++) @(posedge clk);
    #1;
    inv_dir = 1'b1;
    step();
    inv_dir = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
    end
    chk("t5_idle", 64'(bus.busy_o), 64'd0);
    chk("t5_burst_done", 64'(ack_log.size() - base), 64'd16);
    step();
    bus.adr_i = 32'h100;
    @(negedge clk);
    chk("t5_miss_100", 64'(bus.hit_o), 64'd0);
    step();
    bus.adr_i = 32'h200;
    @(negedge clk);
    chk("t5_miss_200", 64'(bus.hit_o), 64'd0);
    step();

    // Invalidate in IDLE: the window stays valid for the pulse cycle only
    fetch(32'h100, lat);
    bus.adr_i = 32'h100;
    inv_dir = 1'b1;
    @(negedge clk);
    chk("inv_cycle_hit", 64'(bus.hit_o), 64'd1);
    step();
    inv_dir = 1'b0;
    @(negedge clk);
    chk("post_inv_miss", 64'(bus.hit_o), 64'd0);
    step();

    // Reset mid-fill aborts and the refill restarts at beat 0
    bus.adr_i = 32'h100;
    bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    base = ack_log.size();
    fetch(32'h100, lat);
    chk("midrst_refill_beats", 64'(ack_log.size() - base), 64'd16);
    if (ack_log.size() > base) chk("midrst_refill_adr", 64'(ack_log[base]), 64'h100);

    // T6 random fetches over aliasing sets, with random ack gaps, errors and invalidates
    ack_pct = 70;
    err_pct = 2;
    inv_rand_en = 1'b1;
    for (int n = 0; n < 800 && n_timeouts < 4; n++) begin
      hi = ($urandom_range(7) == 0) ? 32'hFFFF_E000 : (32'($urandom_range(3)) << 13);
      a  = hi | (32'(idx_tab[$urandom_range(5)]) << 5) | (32'($urandom_range(15)) << 1);
      fetch(a, lat);
    end
    inv_rand_en = 1'b0;
    err_pct = 0;
    repeat (3) step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
